// File: rtl/conv_sched.sv
// conv_sched: two-requester scheduler for a shared fixed/float converter.
//
// Requesters A and B each present an operand, fixed-point position and
// direction. Requests are accepted one at a time in IDLE. When both are
// pending, a round-robin pointer gives the grant to the port not served last.
// The accepted operand is held on the cv_* outputs for LATENCY+1 cycles in
// ISSUE. cv_result is then captured into r_data. In RESP the result is
// offered to the granted requester only, until that requester accepts it.
//
// Ports:
//   clk, rst                   clock, asynchronous active-low reset
//   a_/b_valid, _ready         request handshake (ready is combinational, IDLE only)
//   a_/b_number, _fixpos, _op  request operands
//   a_/b_rvalid, _rready       response handshake
//   r_data                     captured converter result (shared)
//   cv_number/fixpos/opcode    held operands driven to the converter
//   cv_result                  converter output
//   busy                       scheduler is not in IDLE
module conv_sched #(
  parameter int unsigned LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [31:0] a_number,
  input  logic [4:0]  a_fixpos,
  input  logic        a_op,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [31:0] b_number,
  input  logic [4:0]  b_fixpos,
  input  logic        b_op,
  output logic        a_rvalid,
  output logic        b_rvalid,
  input  logic        a_rready,
  input  logic        b_rready,
  output logic [31:0] r_data,
  output logic [31:0] cv_number,
  output logic [4:0]  cv_fixpos,
  output logic        cv_opcode,
  input  logic [31:0] cv_result,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        last_b_q;   // 1: B was served last, so A wins the next tie
  logic        gnt_b_q;    // 1: the in-flight request belongs to B
  logic [31:0] num_q;
  logic [4:0]  fix_q;
  logic        op_q;
  logic [31:0] data_q;
  logic        a_rvalid_q;
  logic        b_rvalid_q;
  logic        busy_q;
  logic        pick_b;
  logic        idle_ok;

  // B wins if it is the only requester, or on a tie when A was served last.
  always_comb begin
    pick_b  = b_valid && (!a_valid || !last_b_q);
    idle_ok = rst && (state_q == IDLE);
    a_ready = idle_ok && a_valid && !pick_b;
    b_ready = idle_ok && pick_b;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      last_b_q   <= 1'b1;
      gnt_b_q    <= 1'b0;
      num_q      <= '0;
      fix_q      <= '0;
      op_q       <= 1'b0;
      data_q     <= '0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (a_ready || b_ready) begin
            num_q    <= b_ready ? b_number : a_number;
            fix_q    <= b_ready ? b_fixpos : a_fixpos;
            op_q     <= b_ready ? b_op     : a_op;
            gnt_b_q  <= b_ready;
            last_b_q <= b_ready;
            cnt_q    <= 4'(LATENCY);
            busy_q   <= 1'b1;
            state_q  <= ISSUE;
          end
        end
        ISSUE: begin
          // Counter runs LATENCY..0, giving LATENCY+1 cycles in ISSUE.
          if (cnt_q == '0) begin
            data_q     <= cv_result;
            a_rvalid_q <= !gnt_b_q;
            b_rvalid_q <= gnt_b_q;
            state_q    <= RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          if ((a_rvalid_q && a_rready) || (b_rvalid_q && b_rready)) begin
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            busy_q     <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign a_rvalid  = a_rvalid_q;
  assign b_rvalid  = b_rvalid_q;
  assign r_data    = data_q;
  assign cv_number = num_q;
  assign cv_fixpos = fix_q;
  assign cv_opcode = op_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_conv_sched.sv
module tb_conv_sched;

  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  // LATENCY=1 instance
  logic        a_valid, a_ready, a_op, b_valid, b_ready, b_op;
  logic [31:0] a_number, b_number, r_data, cv_number, cv_result;
  logic [4:0]  a_fixpos, b_fixpos, cv_fixpos;
  logic        a_rvalid, b_rvalid, a_rready, b_rready, cv_opcode, busy;

  // LATENCY=3 instance
  logic        x_a_valid, x_a_ready, x_a_op, x_b_valid, x_b_ready, x_b_op;
  logic [31:0] x_a_number, x_b_number, x_r_data, x_cv_number, x_cv_result;
  logic [4:0]  x_a_fixpos, x_b_fixpos, x_cv_fixpos;
  logic        x_a_rvalid, x_b_rvalid, x_a_rready, x_b_rready, x_cv_opcode, x_busy;

  int checks = 0;
  int errors = 0;

  conv_sched #(.LATENCY(1)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_number(a_number), .a_fixpos(a_fixpos), .a_op(a_op),
    .b_valid(b_valid), .b_ready(b_ready), .b_number(b_number), .b_fixpos(b_fixpos), .b_op(b_op),
    .a_rvalid(a_rvalid), .b_rvalid(b_rvalid), .a_rready(a_rready), .b_rready(b_rready),
    .r_data(r_data), .cv_number(cv_number), .cv_fixpos(cv_fixpos), .cv_opcode(cv_opcode),
    .cv_result(cv_result), .busy(busy)
  );

  conv_sched #(.LATENCY(3)) dut3 (
    .clk(clk), .rst(rst),
    .a_valid(x_a_valid), .a_ready(x_a_ready), .a_number(x_a_number), .a_fixpos(x_a_fixpos), .a_op(x_a_op),
    .b_valid(x_b_valid), .b_ready(x_b_ready), .b_number(x_b_number), .b_fixpos(x_b_fixpos), .b_op(x_b_op),
    .a_rvalid(x_a_rvalid), .b_rvalid(x_b_rvalid), .a_rready(x_a_rready), .b_rready(x_b_rready),
    .r_data(x_r_data), .cv_number(x_cv_number), .cv_fixpos(x_cv_fixpos), .cv_opcode(x_cv_opcode),
    .cv_result(x_cv_result), .busy(x_busy)
  );

  // Converter behaviour: op=1 single float -> signed fixed, op=0 signed fixed -> single float.
  function automatic logic [31:0] conv(input logic [31:0] n, input logic [4:0] fp, input logic op);
    real         scale;
    real         r;
    logic [63:0] d;
    logic [10:0] e;
    scale = 1.0;
    for (int i = 0; i < int'(fp); i++) scale = scale * 2.0;
    if (op) begin
      if (n[30:23] == 8'd0) return 32'd0;
      e = {3'b000, n[30:23]} + 11'd896;
      d = {n[31], e, n[22:0], 29'd0};
      r = $bitstoreal(d) * scale;
      return 32'($rtoi(r));
    end else begin
      if (n == 32'd0) return 32'd0;
      r = $itor($signed(n)) / scale;
      d = $realtobits(r);
      e = d[62:52] - 11'd896;
      return {d[63], e[7:0], d[51:29]};
    end
  endfunction

  // One registered stage for the LATENCY=1 instance, three for LATENCY=3.
  logic [31:0] p0, p1, p2;
  always @(posedge clk) begin
    cv_result <= conv(cv_number, cv_fixpos, cv_opcode);
    p0 <= conv(x_cv_number, x_cv_fixpos, x_cv_opcode);
    p1 <= p0;
    p2 <= p1;
  end
  assign x_cv_result = p2;

  typedef struct {
    logic        sel;  // 0 = A, 1 = B
    logic [31:0] num;
    logic [4:0]  fp;
    logic        op;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_valid(input logic sel, input logic v);
    if (sel) b_valid = v; else a_valid = v;
  endtask

  task automatic set_req(input logic sel, input vec_t v);
    if (sel) begin
      b_valid = 1'b1; b_number = v.num; b_fixpos = v.fp; b_op = v.op;
    end else begin
      a_valid = 1'b1; a_number = v.num; a_fixpos = v.fp; a_op = v.op;
    end
  endtask

  task automatic set_rready(input logic sel, input logic v);
    if (sel) b_rready = v; else a_rready = v;
  endtask

  // Present a request and expect it to be accepted in the current cycle.
  task automatic start_txn(input vec_t v);
    set_req(v.sel, v);
    set_rready(v.sel, 1'b0);
    set_rready(!v.sel, 1'b1);
    #1;
    chk("ready_grant", v.sel ? b_ready : a_ready, 1);
    chk("ready_other", v.sel ? a_ready : b_ready, 0);
  endtask

  // Follow an accepted request through ISSUE and RESP (LATENCY=1: rvalid at C+3).
  task automatic finish_txn(input vec_t v, input int hold, input bit drop);
    logic [31:0] held;
    for (int k = 1; k <= 3; k++) begin
      tick();
      if (k == 1 && drop) set_valid(v.sel, 1'b0);
      #1;
      if (k < 3) begin
        chk("cv_number", cv_number, v.num);
        chk("cv_fixpos", 32'(cv_fixpos), 32'(v.fp));
        chk("cv_opcode", 32'(cv_opcode), 32'(v.op));
      end
      chk("rvalid_latency", v.sel ? b_rvalid : a_rvalid, (k == 3) ? 1 : 0);
      chk("rvalid_other", v.sel ? a_rvalid : b_rvalid, 0);
      chk("ready_while_busy", {30'd0, a_ready, b_ready}, 0);
      chk("busy_inflight", 32'(busy), 1);
    end
    chk("r_data", r_data, v.exp);
    held = r_data;
    for (int h = 0; h < hold; h++) begin
      tick();
      #1;
      chk("rvalid_hold", v.sel ? b_rvalid : a_rvalid, 1);
      chk("r_data_hold", r_data, held);
      chk("ready_in_resp", {30'd0, a_ready, b_ready}, 0);
      chk("busy_in_resp", 32'(busy), 1);
    end
    set_rready(v.sel, 1'b1);
    tick();
    set_rready(v.sel, 1'b0);
    #1;
    chk("busy_after_hs", 32'(busy), 0);
    chk("rvalid_after_hs", {30'd0, a_rvalid, b_rvalid}, 0);
  endtask

  task automatic pulse_reset();
    #2 rst = 1'b0;
    #2 rst = 1'b1;
    tick();
  endtask

  // Random-run state
  logic        rv[2], rr[2], rop[2], acc_prev[2];
  logic [31:0] rnum[2];
  logic [4:0]  rfp[2];
  logic        m_free, m_last_b, m_gnt_b, ea, eb, due;
  int          m_acc;
  logic [31:0] m_exp;

  initial begin
    tbl[0] = '{1'b0, 32'h0000_0180, 5'd8, 1'b0, 32'h3FC0_0000};
    tbl[1] = '{1'b0, 32'h0000_0001, 5'd0, 1'b0, 32'h3F80_0000};
    tbl[2] = '{1'b1, 32'h4020_0000, 5'd4, 1'b1, 32'h0000_0028};
    tbl[3] = '{1'b1, 32'hC040_0000, 5'd2, 1'b1, 32'hFFFF_FFF4};
    tbl[4] = '{1'b0, 32'hFFFF_FF00, 5'd8, 1'b0, 32'hBF80_0000};
    tbl[5] = '{1'b1, 32'h3F80_0000, 5'd0, 1'b1, 32'h0000_0001};

    rst = 1'b0;
    a_valid = 1'b1; b_valid = 1'b1; a_rready = 1'b0; b_rready = 1'b0;
    a_number = 32'h1234_5678; b_number = 32'h9ABC_DEF0;
    a_fixpos = 5'd3; b_fixpos = 5'd7; a_op = 1'b1; b_op = 1'b0;
    x_a_valid = 1'b0; x_b_valid = 1'b0; x_a_rready = 1'b0; x_b_rready = 1'b0;
    x_a_number = '0; x_b_number = '0; x_a_fixpos = '0; x_b_fixpos = '0;
    x_a_op = 1'b0; x_b_op = 1'b0;

    // Reset state, with both requesters valid
    #12;
    chk("rst_ready", {30'd0, a_ready, b_ready}, 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rvalid", {30'd0, a_rvalid, b_rvalid}, 0);
    chk("rst_r_data", r_data, 0);
    chk("rst_cv_number", cv_number, 0);
    chk("rst_cv_fix_op", {26'd0, cv_fixpos, cv_opcode}, 0);
    chk("rst_x_busy", 32'(x_busy), 0);
    a_valid = 1'b0; b_valid = 1'b0;
    #1 rst = 1'b1;
    tick();

    // Table of single transactions; consecutive rows also exercise back-to-back accepts
    for (int i = 0; i < 6; i++) begin
      start_txn(tbl[i]);
      finish_txn(tbl[i], i % 3, 1'b1);
    end

    // Round-robin: tie after reset goes to A, then B, then A again
    pulse_reset();
    set_req(1'b1, tbl[2]);
    start_txn(tbl[0]);
    finish_txn(tbl[0], 0, 1'b0);
    #1;
    chk("rr_second_b", {30'd0, a_ready, b_ready}, 32'd1);
    set_rready(1'b1, 1'b0);
    set_rready(1'b0, 1'b1);
    finish_txn(tbl[2], 5, 1'b1);
    set_req(1'b1, tbl[3]);
    #1;
    chk("rr_third_a", {30'd0, a_ready, b_ready}, 32'd2);
    set_rready(1'b0, 1'b0);
    set_rready(1'b1, 1'b1);
    finish_txn(tbl[0], 0, 1'b1);
    b_valid = 1'b0;

    // LATENCY=3: rvalid at C+5, converter inputs constant for 4 cycles
    x_a_valid = 1'b1; x_a_number = 32'h4020_0000; x_a_fixpos = 5'd4; x_a_op = 1'b1;
    #1;
    chk("l3_ready", 32'(x_a_ready), 1);
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k == 1) x_a_valid = 1'b0;
      #1;
      if (k <= 4) chk("l3_cv_hold", {x_cv_number[26:0], x_cv_fixpos}, {27'h020_0000, 5'd4});
      chk("l3_rvalid_latency", 32'(x_a_rvalid), (k == 5) ? 1 : 0);
    end
    chk("l3_r_data", x_r_data, 32'h0000_0028);
    x_a_rready = 1'b1;
    tick();
    x_a_rready = 1'b0;
    #1;
    chk("l3_idle_after", {30'd0, x_busy, x_a_rvalid}, 0);

    // Reset asynchronously in the middle of ISSUE
    start_txn(tbl[4]);
    tick();
    a_valid = 1'b0;
    #1;
    chk("mid_issue_busy", 32'(busy), 1);
    a_valid = 1'b1;
    #1 rst = 1'b0;
    #1;
    chk("async_busy", 32'(busy), 0);
    chk("async_ready", 32'(a_ready), 0);
    chk("async_cv_number", cv_number, 0);
    chk("async_r_data", r_data, 0);
    chk("async_rvalid", {30'd0, a_rvalid, b_rvalid}, 0);
    a_valid = 1'b0;
    #3 rst = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("no_resp_after_rst", {30'd0, a_rvalid, busy}, 0);
    end
    start_txn(tbl[4]);
    finish_txn(tbl[4], 1, 1'b1);

    // Randomised traffic against a transaction-level model
    pulse_reset();
    m_free = 1'b1; m_last_b = 1'b1; m_gnt_b = 1'b0; m_acc = 0; m_exp = '0;
    for (int i = 0; i < 2; i++) begin
      rv[i] = 1'b0; rr[i] = 1'b0; acc_prev[i] = 1'b0;
      rnum[i] = '0; rfp[i] = '0; rop[i] = 1'b0;
    end
    for (int n = 0; n < 3000; n++) begin
      tick();
      for (int i = 0; i < 2; i++) begin
        if (!rv[i] || acc_prev[i]) begin
          rv[i]  = ($urandom % 3) == 0;
          rop[i] = 1'($urandom % 2);
          rfp[i] = 5'($urandom % 32);
          if (rop[i]) rnum[i] = {1'($urandom % 2), 8'($urandom_range(100, 125)), 23'($urandom)};
          else        rnum[i] = $urandom;
        end else if (($urandom % 16) == 0) begin
          rv[i] = 1'b0;
        end
        rr[i] = 1'($urandom % 2);
        acc_prev[i] = 1'b0;
      end
      a_valid = rv[0]; a_number = rnum[0]; a_fixpos = rfp[0]; a_op = rop[0]; a_rready = rr[0];
      b_valid = rv[1]; b_number = rnum[1]; b_fixpos = rfp[1]; b_op = rop[1]; b_rready = rr[1];
      #1;
      if (m_free) begin
        ea = rv[0] && (!rv[1] || m_last_b);
        eb = rv[1] && !ea;
        chk("rnd_ready", {30'd0, a_ready, b_ready}, {30'd0, ea, eb});
        chk("rnd_idle_out", {30'd0, busy, a_rvalid || b_rvalid}, 0);
        if (ea || eb) begin
          m_free = 1'b0; m_gnt_b = eb; m_last_b = eb; m_acc = n;
          m_exp = conv(rnum[eb], rfp[eb], rop[eb]);
          acc_prev[eb] = 1'b1;
        end
      end else begin
        due = (n >= m_acc + 3);
        chk("rnd_ready_busy", {30'd0, a_ready, b_ready}, 0);
        chk("rnd_busy", 32'(busy), 1);
        chk("rnd_rvalid", {30'd0, a_rvalid, b_rvalid}, {30'd0, due && !m_gnt_b, due && m_gnt_b});
        if (due) begin
          chk("rnd_r_data", r_data, m_exp);
          if (rr[m_gnt_b]) m_free = 1'b1;
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_sched.md
CONV_SCHED -- requirements
Module: conv_sched

Interface
REQ-001 SHALL have parameter LATENCY, default 1, meaning clock edges from stable converter inputs to a valid cv_result (legal range 1..15).
REQ-002 SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, meaning reset; asynchronous, active-low.
REQ-004 SHALL have port a_valid, input, 1, meaning requester A has a conversion pending.
REQ-005 SHALL have port a_ready, output, 1, meaning A's request is accepted this cycle.
REQ-006 SHALL have port a_number, input, 32, meaning A's operand.
REQ-007 SHALL have port a_fixpos, input, 5, meaning A's fixed-point position.
REQ-008 SHALL have port a_op, input, 1, meaning A's direction: 1 = float to fix, 0 = fix to float.
REQ-009 SHALL have ports b_valid, b_ready, b_number, b_fixpos and b_op, with the same directions, widths and meanings as REQ-004 to REQ-008, for requester B.
REQ-010 SHALL have ports a_rvalid and b_rvalid, output, 1, meaning a result is presented to A or to B.
REQ-011 SHALL have ports a_rready and b_rready, input, 1, meaning A or B accepts the presented result.
REQ-012 SHALL have port r_data, output, 32, meaning the captured conversion result, shared by both requesters.
REQ-013 SHALL have ports cv_number (output, 32), cv_fixpos (output, 5) and cv_opcode (output, 1), meaning the converter operand inputs.
REQ-014 SHALL have port cv_result, input, 32, meaning the converter output.
REQ-015 SHALL have port busy, output, 1, meaning the FSM is not in IDLE.

Function
REQ-016 SHALL implement the FSM states IDLE, ISSUE and RESP.
REQ-017 SHALL, in IDLE, assert exactly one of a_ready/b_ready, combinationally, only for a requester whose valid is high; ready SHALL never be asserted outside IDLE.
REQ-018 SHALL arbitrate round-robin: when a_valid and b_valid are both high, the grant goes to the port not served last; a last-served pointer updates on each accept.
REQ-019 SHALL, on an accept (valid & ready), latch the operand, fixpos, op and grant ID, then move to ISSUE on the next edge.
REQ-020 SHALL drive cv_number/cv_fixpos/cv_opcode from the latched registers, holding them constant from the cycle after accept until the capture edge, and retaining the last values while idle.
REQ-021 SHALL remain in ISSUE for exactly LATENCY+1 cycles, using a 4-bit down-counter, then capture cv_result into r_data and move to RESP on the same edge.
REQ-022 SHALL, in RESP, assert only the granted requester's rvalid, with r_data stable, until that requester's rready is high.
REQ-023 SHALL move from RESP to IDLE on the edge where rvalid & rready are both high.
REQ-024 SHALL ignore the non-granted requester's rready at all times.
REQ-025 SHALL make a new accept possible in the cycle after the RESP-to-IDLE edge; there is no pipelining.
REQ-026 SHALL ensure that requests arriving during ISSUE or RESP wait without loss, because ready stays low; requesters hold valid and operands until ready.
REQ-027 SHALL make the accept-to-rvalid latency LATENCY+2 cycles: an accept in cycle C gives rvalid high in cycle C+LATENCY+2.
REQ-028 SHALL treat a requester that drops valid before ready as never having requested; no state change results.
REQ-029 SHALL pass operand values unmodified; no arithmetic on data.

Reset
REQ-030 SHALL, while rst is low, force: state IDLE, busy 0, a_rvalid/b_rvalid 0, r_data 0, cv_number 0, cv_fixpos 0, cv_opcode 0, counter 0, and last-served pointer = B so that A wins the first tie.
REQ-031 SHALL, if reset is asserted mid-ISSUE or mid-RESP, abandon the in-flight request with no response ever issued; after release, the requester re-presents it.
REQ-032 SHALL drive a_ready/b_ready low while rst is low.

Verification
REQ-033 SHALL be verified with the following directed scenarios, using LATENCY=1 and a converter model with one registered cycle:
- A only, number 0x00000180, fixpos 8, op 0, accepted cycle C -> cv_number=0x00000180 at C+1, a_rvalid at C+3, r_data = model result 0x3FC00000; b_rvalid stays 0.
- A and B both valid from reset -> A granted first; B granted in the cycle after A's response handshake; next simultaneous request -> A again.
- B served, a_rready held high, b_rready held low for 5 cycles -> b_rvalid and r_data stay stable for 5 cycles, FSM stays in RESP, a_ready stays 0.
- LATENCY=3, A request B 0x40200000, fixpos 4, op 1 -> a_rvalid exactly 5 cycles after accept; cv inputs constant for 4 cycles.
- rst pulsed low during ISSUE -> all outputs at reset values immediately (asynchronous); no rvalid after release; a re-presented request completes normally.
- Back-to-back A-only requests -> second accept occurs exactly 1 cycle after the first response handshake.
